// File: rtl/wm_pkg.sv
// Shared washing-machine definitions: phase codes, program field layout, sequencer states.
// Also carries the program-type codes used by the setting stage.
// Helper functions extract a phase field, sum a program and decode actuators.
package wm_pkg;

    localparam int PROG_W  = 26;
    localparam int FIELD_W = 4;

    // Phase codes, in execution order
    localparam logic [2:0] PH_WFILL  = 3'd0;
    localparam logic [2:0] PH_WASH   = 3'd1;
    localparam logic [2:0] PH_WDRAIN = 3'd2;
    localparam logic [2:0] PH_WSPIN  = 3'd3;
    localparam logic [2:0] PH_RFILL  = 3'd4;
    localparam logic [2:0] PH_RINSE  = 3'd5;
    localparam logic [2:0] PH_FDRAIN = 3'd6;
    localparam logic [2:0] PH_FSPIN  = 3'd7;

    // Field positions inside the program word, MSB first
    localparam int WFILL_MSB  = 25;
    localparam int WFILL_LSB  = 23;
    localparam int WASH_MSB   = 22;
    localparam int WASH_LSB   = 19;
    localparam int WDRAIN_MSB = 18;
    localparam int WDRAIN_LSB = 16;
    localparam int WSPIN_MSB  = 15;
    localparam int WSPIN_LSB  = 13;
    localparam int RFILL_MSB  = 12;
    localparam int RFILL_LSB  = 10;
    localparam int RINSE_MSB  = 9;
    localparam int RINSE_LSB  = 6;
    localparam int FDRAIN_MSB = 5;
    localparam int FDRAIN_LSB = 3;
    localparam int FSPIN_MSB  = 2;
    localparam int FSPIN_LSB  = 0;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_e;

    // Program-type codes shared with the setting stage
    localparam logic [2:0] WRD = 3'd0;
    localparam logic [2:0] W   = 3'd1;
    localparam logic [2:0] WR  = 3'd2;
    localparam logic [2:0] R   = 3'd3;
    localparam logic [2:0] RD  = 3'd4;
    localparam logic [2:0] D   = 3'd5;
    localparam logic [2:0] USE = 3'd6;

    // Duration field of one phase, zero-extended to 4 bits
    function automatic logic [FIELD_W-1:0] field_of(input logic [PROG_W-1:0] prog,
                                                    input logic [2:0] idx);
        logic [FIELD_W-1:0] f;
        case (idx)
            PH_WFILL:  f = {1'b0, prog[WFILL_MSB:WFILL_LSB]};
            PH_WASH:   f = prog[WASH_MSB:WASH_LSB];
            PH_WDRAIN: f = {1'b0, prog[WDRAIN_MSB:WDRAIN_LSB]};
            PH_WSPIN:  f = {1'b0, prog[WSPIN_MSB:WSPIN_LSB]};
            PH_RFILL:  f = {1'b0, prog[RFILL_MSB:RFILL_LSB]};
            PH_RINSE:  f = prog[RINSE_MSB:RINSE_LSB];
            PH_FDRAIN: f = {1'b0, prog[FDRAIN_MSB:FDRAIN_LSB]};
            default:   f = {1'b0, prog[FSPIN_MSB:FSPIN_LSB]};
        endcase
        return f;
    endfunction

    // Whole-program duration in ticks (max 72, fits in 8 bits)
    function automatic logic [7:0] sum_fields(input logic [PROG_W-1:0] prog);
        logic [7:0] s;
        s = 8'd0;
        for (int i = 0; i < 8; i++) begin
            s = s + {4'd0, field_of(prog, 3'(i))};
        end
        return s;
    endfunction

    // Actuator pattern for a phase: {water_in, water_out, motor_wash, motor_spin}
    function automatic logic [3:0] act_of(input logic [2:0] ph);
        logic [3:0] a;
        case (ph)
            PH_WFILL, PH_RFILL:   a = 4'b1000;
            PH_WASH, PH_RINSE:    a = 4'b0010;
            PH_WDRAIN, PH_FDRAIN: a = 4'b0100;
            default:              a = 4'b0101;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/wm_phase_pick.sv
// Finds the lowest-index phase at or above i_start whose duration field is nonzero.
// Purely combinational, zero latency.
// No flow control; i_start of 8 means no phase is eligible.
module wm_phase_pick
    import wm_pkg::*;
(
    input  logic [PROG_W-1:0]  i_program,
    input  logic [3:0]         i_start,
    output logic               o_found,
    output logic [2:0]         o_idx,
    output logic [FIELD_W-1:0] o_field
);

    // Scan downwards so the lowest eligible index is the one that sticks
    always_comb begin
        o_found = 1'b0;
        o_idx   = 3'd0;
        o_field = '0;
        for (int i = 7; i >= 0; i--) begin
            if ((4'(i) >= i_start) && (field_of(i_program, 3'(i)) != '0)) begin
                o_found = 1'b1;
                o_idx   = 3'(i);
                o_field = field_of(i_program, 3'(i));
            end
        end
    end

endmodule

// File: rtl/wash_sequencer.sv
// Runs an eight-phase wash program, counting each phase down on 1 s ticks and skipping empty ones.
// Counters change on the tick edge; actuators follow the phase one cycle later.
// pause freezes counting and drops simultaneous ticks; abort returns to IDLE from anywhere.
module wash_sequencer
    import wm_pkg::*;
#(
    parameter int TOTAL_W = 8
) (
    input  logic               i_cp,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic               i_pause,
    input  logic               i_abort,
    input  logic               i_clear,
    input  logic               i_tick,
    input  logic [PROG_W-1:0]  i_program,
    output logic [2:0]         o_phase,
    output logic [3:0]         o_phase_remaining,
    output logic [TOTAL_W-1:0] o_total_remaining,
    output logic               o_water_in,
    output logic               o_water_out,
    output logic               o_motor_wash,
    output logic               o_motor_spin,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_done_pulse
);

    seq_state_e         r_state;
    logic [PROG_W-1:0]  r_prog;
    logic [2:0]         r_phase;
    logic [3:0]         r_prem;
    logic [TOTAL_W-1:0] r_total;
    logic [3:0]         r_act;
    logic               r_done_pulse;

    logic [PROG_W-1:0]  w_pick_prog;
    logic [3:0]         w_pick_start;
    logic               w_found;
    logic [2:0]         w_idx;
    logic [3:0]         w_field;
    logic [7:0]         w_sum;

    // In IDLE the picker looks at the live input so the first phase is chosen on the start edge;
    // while running it searches the latched program above the current phase.
    assign w_pick_prog  = (r_state == ST_IDLE) ? i_program : r_prog;
    assign w_pick_start = (r_state == ST_IDLE) ? 4'd0 : ({1'b0, r_phase} + 4'd1);
    assign w_sum        = sum_fields(i_program);

    wm_phase_pick u_pick (
        .i_program (w_pick_prog),
        .i_start   (w_pick_start),
        .o_found   (w_found),
        .o_idx     (w_idx),
        .o_field   (w_field)
    );

    // Sequencer state, counters and registered actuator enables
    always_ff @(posedge i_cp) begin
        if (i_reset) begin
            r_state      <= ST_IDLE;
            r_prog       <= '0;
            r_phase      <= 3'd0;
            r_prem       <= 4'd0;
            r_total      <= '0;
            r_act        <= 4'd0;
            r_done_pulse <= 1'b0;
        end else if (i_abort) begin
            r_state      <= ST_IDLE;
            r_phase      <= 3'd0;
            r_prem       <= 4'd0;
            r_total      <= '0;
            r_act        <= 4'd0;
            r_done_pulse <= 1'b0;
        end else begin
            r_done_pulse <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_act <= 4'd0;
                    if (i_start) begin
                        r_prog <= i_program;
                        if (w_found) begin
                            r_state <= ST_RUN;
                            r_phase <= w_idx;
                            r_prem  <= w_field;
                            r_total <= TOTAL_W'(w_sum);
                        end else begin
                            r_state      <= ST_DONE;
                            r_phase      <= 3'd0;
                            r_prem       <= 4'd0;
                            r_total      <= '0;
                            r_done_pulse <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (i_pause) begin
                        r_state <= ST_PAUSE;
                        r_act   <= 4'd0;
                    end else begin
                        r_act <= act_of(r_phase);
                        if (i_tick) begin
                            if (r_prem > 4'd1) begin
                                r_prem  <= r_prem - 4'd1;
                                r_total <= r_total - TOTAL_W'(1);
                            end else if (w_found) begin
                                r_phase <= w_idx;
                                r_prem  <= w_field;
                                r_total <= r_total - TOTAL_W'(1);
                            end else begin
                                // Last phase finished: phase index is kept as the final one
                                r_state      <= ST_DONE;
                                r_prem       <= 4'd0;
                                r_total      <= '0;
                                r_act        <= 4'd0;
                                r_done_pulse <= 1'b1;
                            end
                        end
                    end
                end
                ST_PAUSE: begin
                    r_act <= 4'd0;
                    if (!i_pause) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_DONE: begin
                    r_act <= 4'd0;
                    if (i_clear) begin
                        r_state <= ST_IDLE;
                        r_phase <= 3'd0;
                        r_prem  <= 4'd0;
                        r_total <= '0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_act   <= 4'd0;
                end
            endcase
        end
    end

    assign o_phase           = r_phase;
    assign o_phase_remaining = r_prem;
    assign o_total_remaining = r_total;
    assign o_water_in        = r_act[3];
    assign o_water_out       = r_act[2];
    assign o_motor_wash      = r_act[1];
    assign o_motor_spin      = r_act[0];
    assign o_busy            = (r_state == ST_RUN) || (r_state == ST_PAUSE);
    assign o_done            = (r_state == ST_DONE);
    assign o_done_pulse      = r_done_pulse;

endmodule

// File: tb/tb_wash_sequencer.sv
// Directed bench for wash_sequencer: a vector table of programs and tick counts,
// plus hand sequences for done_pulse timing, pause, abort, clear and reset.
module tb_wash_sequencer;

    logic        cp;
    logic        reset;
    logic        start;
    logic        pause;
    logic        abort;
    logic        clear;
    logic        tick;
    logic [25:0] prog_in;
    logic [2:0]  phase;
    logic [3:0]  prem;
    logic [7:0]  total;
    logic        water_in;
    logic        water_out;
    logic        motor_wash;
    logic        motor_spin;
    logic        busy;
    logic        done;
    logic        done_pulse;

    int n_total;
    int n_bad;

    localparam logic [25:0] P_WRD  = 26'b011_1010_100_101_011_1000_100_101;
    localparam logic [25:0] P_W    = 26'b011_1010_000_000_000_0000_000_000;
    localparam logic [25:0] P_D    = 26'b000_0000_000_000_000_0000_100_101;
    localparam logic [25:0] P_ZERO = 26'b0;
    localparam logic [25:0] P_R    = 26'b000_0000_000_000_010_0011_000_000;
    localparam logic [25:0] P_SP   = 26'b000_1111_000_000_000_0000_000_111;

    typedef struct packed {
        logic [25:0] prog;
        logic [7:0]  ticks;
        logic [2:0]  ph;
        logic [3:0]  prem;
        logic [7:0]  tot;
        logic [3:0]  act;   // {water_in, water_out, motor_wash, motor_spin}
        logic        busy;
        logic        done;
    } vec_t;

    localparam int NVEC = 16;
    vec_t vecs [NVEC];

    wash_sequencer #(.TOTAL_W(8)) dut (
        .i_cp              (cp),
        .i_reset           (reset),
        .i_start           (start),
        .i_pause           (pause),
        .i_abort           (abort),
        .i_clear           (clear),
        .i_tick            (tick),
        .i_program         (prog_in),
        .o_phase           (phase),
        .o_phase_remaining (prem),
        .o_total_remaining (total),
        .o_water_in        (water_in),
        .o_water_out       (water_out),
        .o_motor_wash      (motor_wash),
        .o_motor_spin      (motor_spin),
        .o_busy            (busy),
        .o_done            (done),
        .o_done_pulse      (done_pulse)
    );

    initial cp = 1'b0;
    always #5 cp = ~cp;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mkv(input logic [25:0] p, input int t, input int ph, input int pr,
                                 input int tt, input logic [3:0] a, input logic b, input logic d);
        vec_t v;
        v.prog  = p;
        v.ticks = 8'(t);
        v.ph    = 3'(ph);
        v.prem  = 4'(pr);
        v.tot   = 8'(tt);
        v.act   = a;
        v.busy  = b;
        v.done  = d;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge cp);
        #1;
    endtask

    task automatic do_tick();
        tick = 1'b1;
        step();
        tick = 1'b0;
        step();
    endtask

    // Abort to IDLE, start the program, then let one cycle pass so actuators settle
    task automatic begin_prog(input logic [25:0] p);
        abort = 1'b1;
        step();
        abort = 1'b0;
        prog_in = p;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
    endtask

    function automatic logic [3:0] acts();
        return {water_in, water_out, motor_wash, motor_spin};
    endfunction

    int fire_at;
    int bad_ph;

    initial begin
        n_total = 0;
        n_bad   = 0;
        reset = 1'b1; start = 1'b0; pause = 1'b0; abort = 1'b0;
        clear = 1'b0; tick = 1'b0; prog_in = P_WRD;

        vecs[0]  = mkv(P_WRD,  0, 0,  3, 42, 4'b1000, 1'b1, 1'b0);
        vecs[1]  = mkv(P_WRD,  3, 1, 10, 39, 4'b0010, 1'b1, 1'b0);
        vecs[2]  = mkv(P_WRD, 13, 2,  4, 29, 4'b0100, 1'b1, 1'b0);
        vecs[3]  = mkv(P_WRD, 17, 3,  5, 25, 4'b0101, 1'b1, 1'b0);
        vecs[4]  = mkv(P_WRD, 41, 7,  1,  1, 4'b0101, 1'b1, 1'b0);
        vecs[5]  = mkv(P_WRD, 42, 7,  0,  0, 4'b0000, 1'b0, 1'b1);
        vecs[6]  = mkv(P_W,    0, 0,  3, 13, 4'b1000, 1'b1, 1'b0);
        vecs[7]  = mkv(P_W,   12, 1,  1,  1, 4'b0010, 1'b1, 1'b0);
        vecs[8]  = mkv(P_W,   13, 1,  0,  0, 4'b0000, 1'b0, 1'b1);
        vecs[9]  = mkv(P_D,    0, 6,  4,  9, 4'b0100, 1'b1, 1'b0);
        vecs[10] = mkv(P_D,    4, 7,  5,  5, 4'b0101, 1'b1, 1'b0);
        vecs[11] = mkv(P_D,    9, 7,  0,  0, 4'b0000, 1'b0, 1'b1);
        vecs[12] = mkv(P_ZERO, 0, 0,  0,  0, 4'b0000, 1'b0, 1'b1);
        vecs[13] = mkv(P_R,    0, 4,  2,  5, 4'b1000, 1'b1, 1'b0);
        vecs[14] = mkv(P_R,    2, 5,  3,  3, 4'b0010, 1'b1, 1'b0);
        vecs[15] = mkv(P_SP,  15, 7,  7,  7, 4'b0101, 1'b1, 1'b0);

        // Reset state: every output low
        repeat (3) step();
        reset = 1'b0;
        chk("reset_outputs", {phase, prem, total, acts(), busy, done, done_pulse}, 0);

        // Table-driven runs
        for (int v = 0; v < NVEC; v++) begin
            begin_prog(vecs[v].prog);
            for (int t = 0; t < int'(vecs[v].ticks); t++) do_tick();
            chk($sformatf("v%0d_phase", v), phase, vecs[v].ph);
            chk($sformatf("v%0d_prem", v), prem, vecs[v].prem);
            chk($sformatf("v%0d_total", v), total, vecs[v].tot);
            chk($sformatf("v%0d_act", v), acts(), vecs[v].act);
            chk($sformatf("v%0d_busy", v), busy, vecs[v].busy);
            chk($sformatf("v%0d_done", v), done, vecs[v].done);
        end

        // WRD: done_pulse fires on exactly the 42nd tick and lasts one cycle
        begin_prog(P_WRD);
        fire_at = 0;
        for (int k = 1; k <= 60 && fire_at == 0; k++) begin
            tick = 1'b1;
            step();
            if (done_pulse) fire_at = k;
            tick = 1'b0;
            step();
        end
        chk("wrd_done_pulse_tick", fire_at, 42);
        chk("wrd_done_pulse_width", done_pulse, 0);

        // W-only: done after 13 ticks and phases above 1 never appear
        begin_prog(P_W);
        fire_at = 0;
        bad_ph  = 0;
        for (int k = 1; k <= 40 && fire_at == 0; k++) begin
            tick = 1'b1;
            step();
            if (phase > 3'd1) bad_ph++;
            if (done_pulse) fire_at = k;
            tick = 1'b0;
            step();
            if (phase > 3'd1) bad_ph++;
        end
        chk("w_done_pulse_tick", fire_at, 13);
        chk("w_phase_range", bad_ph, 0);

        // All-zero program: DONE on the start edge, then clear back to IDLE
        abort = 1'b1; step(); abort = 1'b0;
        prog_in = P_ZERO;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("zero_done", done, 1);
        chk("zero_done_pulse", done_pulse, 1);
        chk("zero_total", total, 0);
        chk("zero_busy", busy, 0);
        step();
        chk("zero_pulse_drop", done_pulse, 0);
        chk("zero_done_hold", done, 1);
        clear = 1'b1; step(); clear = 1'b0;
        chk("clear_idle", {busy, done}, 0);

        // Pause with a simultaneous tick at total_remaining=30
        begin_prog(P_WRD);
        for (int t = 0; t < 12; t++) do_tick();
        chk("pause_pre_total", total, 30);
        chk("pause_pre_act", acts(), 4'b0010);
        pause = 1'b1;
        tick  = 1'b1;
        step();
        tick  = 1'b0;
        chk("pause_total", total, 30);
        chk("pause_act", acts(), 0);
        chk("pause_busy", busy, 1);
        for (int t = 0; t < 5; t++) do_tick();
        chk("pause_ticks_total", total, 30);
        chk("pause_ticks_prem", prem, 1);
        chk("pause_ticks_act", acts(), 0);
        pause = 1'b0;
        step();
        tick = 1'b1;
        step();
        tick = 1'b0;
        chk("resume_total", total, 29);
        chk("resume_phase", phase, 2);

        // Abort in phase 5; start while running is ignored
        begin_prog(P_WRD);
        for (int t = 0; t < 25; t++) do_tick();
        chk("abort_pre_phase", phase, 5);
        chk("abort_pre_total", total, 17);
        prog_in = P_ZERO;
        start = 1'b1; step(); start = 1'b0;
        chk("start_ignored_total", total, 17);
        chk("start_ignored_phase", phase, 5);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_outputs", {phase, prem, total, acts(), busy, done, done_pulse}, 0);
        step();
        chk("abort_no_pulse", {busy, done, done_pulse}, 0);

        // Reset together with start: stays in IDLE
        prog_in = P_WRD;
        reset = 1'b1;
        start = 1'b1;
        step();
        reset = 1'b0;
        start = 1'b0;
        step();
        chk("reset_start_busy", busy, 0);
        chk("reset_start_outputs", {phase, prem, total, acts(), done, done_pulse}, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
